pipeline_stall_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Takes ID/EX register indices and decode flags, and detects data hazards:
  - load-use;
  - branch operand dependency.
- Sequences branch resolution (predict not-taken, resolve in EX) and multi-cycle mul/div occupancy.
- Drives PC/IF-ID write enables and IF-ID/ID-EX flushes.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_stall_ctrl_if.sv | 36 +++
 rtl/pipeline_stall_ctrl.sv | 125 ++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the stall/flush sequencer.
// The slave side is the sequencer; the master side is the datapath (or a bench).
interface pipeline_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             MemRead_EX;
    logic             RegWrite_EX;
    logic [4:0]       rt_EX;
    logic [4:0]       rd_EX;
    logic [4:0]       rs_ID;
    logic [4:0]       rt_ID;
    logic             Branch_ID;
    logic             MulDiv_ID;
    logic             branch_taken_EX;

    logic             PC_write;
    logic             IFID_write;
    logic             IFID_flush;
    logic             IDEX_flush;
    logic             mdu_start;
    logic [CNT_W-1:0] stall_cycles;

    modport slave (
        input  MemRead_EX, RegWrite_EX, rt_EX, rd_EX, rs_ID, rt_ID,
               Branch_ID, MulDiv_ID, branch_taken_EX,
        output PC_write, IFID_write, IFID_flush, IDEX_flush, mdu_start,
               stall_cycles
    );

    modport master (
        output MemRead_EX, RegWrite_EX, rt_EX, rd_EX, rs_ID, rt_ID,
               Branch_ID, MulDiv_ID, branch_taken_EX,
        input  PC_write, IFID_write, IFID_flush, IDEX_flush, mdu_start,
               stall_cycles
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard stalls, branch
// resolution, mul/div occupancy and a saturating stall-cycle counter.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// RUN        | normal issue; data hazards stall, branch/mul-div launch
// BR_RESOLVE | branch sits in EX; flush IF/ID and ID/EX when taken
// MD_BUSY    | mul/div occupies the pipe; stall until md_cnt reaches 1
module pipeline_stall_ctrl #(
    parameter int MD_LAT = 8,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_stall_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        BR_RESOLVE = 2'd1,
        MD_BUSY    = 2'd2
    } state_t;

    localparam logic [7:0]       MD_LAT_V = 8'(MD_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       md_cnt;
    logic [7:0]       md_cnt_nxt;
    logic [CNT_W-1:0] stall_cnt;

    logic lu_hz;
    logic br_hz;
    logic data_hz;

    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic mdu_start;

    // Register $0 is hardwired to zero, so it never carries a dependency.
    assign lu_hz = bus.MemRead_EX && (bus.rt_EX != 5'd0) &&
                   ((bus.rt_EX == bus.rs_ID) || (bus.rt_EX == bus.rt_ID));
    assign br_hz = bus.Branch_ID && bus.RegWrite_EX && (bus.rd_EX != 5'd0) &&
                   ((bus.rd_EX == bus.rs_ID) || (bus.rd_EX == bus.rt_ID));
    assign data_hz = lu_hz || br_hz;

    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        mdu_start  = 1'b0;

        case (state)
            RUN: begin
                if (data_hz) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end else if (bus.Branch_ID) begin
                    state_nxt = BR_RESOLVE;
                end else if (bus.MulDiv_ID) begin
                    mdu_start  = 1'b1;
                    md_cnt_nxt = MD_LAT_V;
                    state_nxt  = MD_BUSY;
                end
            end
            BR_RESOLVE: begin
                if (bus.branch_taken_EX) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
                state_nxt = RUN;
            end
            MD_BUSY: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
                md_cnt_nxt = md_cnt - 8'd1;
                // <= 1 also releases a corrupted zero count instead of wrapping
                if (md_cnt <= 8'd1) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        if (reset) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
            mdu_start  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            md_cnt    <= 8'd0;
            stall_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
            if (!pc_write && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign bus.PC_write     = pc_write;
    assign bus.IFID_write   = ifid_write;
    assign bus.IFID_flush   = ifid_flush;
    assign bus.IDEX_flush   = idex_flush;
    assign bus.mdu_start    = mdu_start;
    assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: hazards, branch resolve, mul/div
// occupancy, reset mid-busy, and counter saturation on a narrow instance.
module tb_pipeline_stall_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    pipeline_stall_ctrl_if #(.CNT_W(16)) bus ();
    pipeline_stall_ctrl_if #(.CNT_W(4))  sat_bus ();

    pipeline_stall_ctrl #(.MD_LAT(8), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    pipeline_stall_ctrl #(.MD_LAT(8), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (sat_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.MemRead_EX      = 1'b0;
        bus.RegWrite_EX     = 1'b0;
        bus.rt_EX           = 5'd0;
        bus.rd_EX           = 5'd0;
        bus.rs_ID           = 5'd0;
        bus.rt_ID           = 5'd0;
        bus.Branch_ID       = 1'b0;
        bus.MulDiv_ID       = 1'b0;
        bus.branch_taken_EX = 1'b0;
    endtask

    task automatic clear_sat_inputs();
        sat_bus.MemRead_EX      = 1'b0;
        sat_bus.RegWrite_EX     = 1'b0;
        sat_bus.rt_EX           = 5'd0;
        sat_bus.rd_EX           = 5'd0;
        sat_bus.rs_ID           = 5'd0;
        sat_bus.rt_ID           = 5'd0;
        sat_bus.Branch_ID       = 1'b0;
        sat_bus.MulDiv_ID       = 1'b0;
        sat_bus.branch_taken_EX = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        clear_inputs();
        clear_sat_inputs();

        // reset forces defaults even with a mul/div request present
        bus.MulDiv_ID = 1'b1;
        tick();
        tick();
        #1;
        check("rst_pc_write", 32'(bus.PC_write), 1);
        check("rst_mdu_start", 32'(bus.mdu_start), 0);
        check("rst_stall_cycles", 32'(bus.stall_cycles), 0);
        clear_inputs();
        reset = 1'b0;
        tick();

        // load-use on rs
        bus.MemRead_EX = 1'b1; bus.rt_EX = 5'd5; bus.rs_ID = 5'd5;
        #1;
        check("lu_pc_write", 32'(bus.PC_write), 0);
        check("lu_ifid_write", 32'(bus.IFID_write), 0);
        check("lu_idex_flush", 32'(bus.IDEX_flush), 1);
        check("lu_ifid_flush", 32'(bus.IFID_flush), 0);
        tick();
        clear_inputs();
        #1;
        check("lu_after_pc_write", 32'(bus.PC_write), 1);
        check("lu_after_stall_cycles", 32'(bus.stall_cycles), 1);

        // $0 never creates a hazard
        bus.MemRead_EX = 1'b1; bus.rt_EX = 5'd0; bus.rs_ID = 5'd0;
        #1;
        check("lu_r0_pc_write", 32'(bus.PC_write), 1);
        check("lu_r0_idex_flush", 32'(bus.IDEX_flush), 0);
        tick();
        clear_inputs();
        #1;
        check("lu_r0_stall_cycles", 32'(bus.stall_cycles), 1);

        // load-use on rt
        bus.MemRead_EX = 1'b1; bus.rt_EX = 5'd7; bus.rt_ID = 5'd7;
        #1;
        check("lu_rt_pc_write", 32'(bus.PC_write), 0);
        tick();
        clear_inputs();
        #1;
        check("lu_rt_stall_cycles", 32'(bus.stall_cycles), 2);

        // branch dependency, then resolve taken
        bus.Branch_ID = 1'b1; bus.RegWrite_EX = 1'b1; bus.rd_EX = 5'd3; bus.rt_ID = 5'd3;
        #1;
        check("brhz_pc_write", 32'(bus.PC_write), 0);
        check("brhz_idex_flush", 32'(bus.IDEX_flush), 1);
        tick();
        bus.RegWrite_EX = 1'b0;
        #1;
        check("br_issue_pc_write", 32'(bus.PC_write), 1);
        check("br_issue_stall_cycles", 32'(bus.stall_cycles), 3);
        tick();
        clear_inputs();
        bus.branch_taken_EX = 1'b1;
        #1;
        check("br_taken_ifid_flush", 32'(bus.IFID_flush), 1);
        check("br_taken_idex_flush", 32'(bus.IDEX_flush), 1);
        check("br_taken_pc_write", 32'(bus.PC_write), 1);
        tick();
        #1;
        check("br_back_run_ifid_flush", 32'(bus.IFID_flush), 0);
        clear_inputs();

        // branch not taken; hazards ignored during resolve
        bus.Branch_ID = 1'b1;
        tick();
        clear_inputs();
        bus.MemRead_EX = 1'b1; bus.rt_EX = 5'd5; bus.rs_ID = 5'd5;
        #1;
        check("br_nt_pc_write", 32'(bus.PC_write), 1);
        check("br_nt_ifid_flush", 32'(bus.IFID_flush), 0);
        check("br_nt_idex_flush", 32'(bus.IDEX_flush), 0);
        tick();
        clear_inputs();
        #1;
        check("br_nt_stall_cycles", 32'(bus.stall_cycles), 3);

        // mul/div: one launch pulse, 8 stall cycles, branch ignored while busy
        bus.MulDiv_ID = 1'b1;
        #1;
        check("md_start", 32'(bus.mdu_start), 1);
        check("md_start_pc_write", 32'(bus.PC_write), 1);
        tick();
        bus.MulDiv_ID = 1'b0;
        bus.Branch_ID = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("md_busy%0d_pc_write", i), 32'(bus.PC_write), 0);
            check($sformatf("md_busy%0d_idex_flush", i), 32'(bus.IDEX_flush), 1);
            check($sformatf("md_busy%0d_mdu_start", i), 32'(bus.mdu_start), 0);
            tick();
        end
        clear_inputs();
        #1;
        check("md_done_pc_write", 32'(bus.PC_write), 1);
        check("md_done_idex_flush", 32'(bus.IDEX_flush), 0);
        check("md_stall_cycles", 32'(bus.stall_cycles), 11);
        bus.branch_taken_EX = 1'b1;
        #1;
        check("md_branch_ignored", 32'(bus.IFID_flush), 0);
        tick();
        clear_inputs();

        // Branch_ID and MulDiv_ID together: branch wins
        bus.Branch_ID = 1'b1; bus.MulDiv_ID = 1'b1;
        #1;
        check("sim_mdu_start", 32'(bus.mdu_start), 0);
        check("sim_pc_write", 32'(bus.PC_write), 1);
        tick();
        clear_inputs();
        bus.branch_taken_EX = 1'b1;
        #1;
        check("sim_in_resolve", 32'(bus.IFID_flush), 1);
        tick();
        clear_inputs();

        // load-use with branch: stall wins, stays RUN
        bus.MemRead_EX = 1'b1; bus.rt_EX = 5'd4; bus.rs_ID = 5'd4; bus.Branch_ID = 1'b1;
        #1;
        check("lu_br_pc_write", 32'(bus.PC_write), 0);
        tick();
        clear_inputs();
        bus.branch_taken_EX = 1'b1;
        #1;
        check("lu_br_stays_run", 32'(bus.IFID_flush), 0);
        check("lu_br_stall_cycles", 32'(bus.stall_cycles), 12);
        tick();
        clear_inputs();

        // reset while md_cnt==4
        bus.MulDiv_ID = 1'b1;
        tick();
        clear_inputs();
        for (int i = 0; i < 4; i++) tick();
        #1;
        check("mdrst_busy_before", 32'(bus.PC_write), 0);
        reset = 1'b1;
        #1;
        check("mdrst_forced_pc_write", 32'(bus.PC_write), 1);
        check("mdrst_forced_idex_flush", 32'(bus.IDEX_flush), 0);
        tick();
        reset = 1'b0;
        #1;
        check("mdrst_stall_cycles", 32'(bus.stall_cycles), 0);
        check("mdrst_pc_write", 32'(bus.PC_write), 1);
        check("mdrst_idex_flush", 32'(bus.IDEX_flush), 0);
        tick();
        #1;
        check("mdrst_run_pc_write", 32'(bus.PC_write), 1);

        // saturation on the 4-bit instance
        sat_bus.MemRead_EX = 1'b1; sat_bus.rt_EX = 5'd5; sat_bus.rs_ID = 5'd5;
        for (int i = 0; i < 14; i++) tick();
        #1;
        check("sat_at14", 32'(sat_bus.stall_cycles), 14);
        for (int i = 0; i < 6; i++) tick();
        #1;
        check("sat_hold15", 32'(sat_bus.stall_cycles), 15);
        clear_sat_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
